// File: rtl/wb_stage_pkg.sv
// Shared constants and slot-selection encoding for the write-back stage.
// Optional WB_FIFO_BYPASS_EN lets a divider result skip an empty FIFO.
package wb_stage_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic STOP         = 1'b1;

  // Which source owns the register-file write port at the next edge.
  typedef enum logic [2:0] {
    SLOT_HOLD,
    SLOT_MEM,
    SLOT_DRAIN,
    SLOT_BYPASS,
    SLOT_IDLE
  } slot_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of late divider results {valid, wd, wdata}.
// Resident entries can be invalidated in place by destination register (kill).
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-1:0]          push_wd,
  input  logic [DW-1:0]          push_wdata,
  input  logic                   pop,
  input  logic                   kill_en,
  input  logic [AW-1:0]          kill_wd,
  output logic                   head_valid,
  output logic [AW-1:0]          head_wd,
  output logic [DW-1:0]          head_wdata,
  output logic [$clog2(DEPTH):0] count
);
  import wb_stage_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] wd_q, wd_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;

  always_comb begin
    valid_d  = valid_q;
    wd_d     = wd_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    // Kill sees only entries already stored; a same-cycle push lands afterwards.
    for (int i = 0; i < DEPTH; i++)
      if (kill_en && wd_q[i] == kill_wd) valid_d[i] = 1'b0;
    if (push) begin
      valid_d[wr_ptr_q] = (push_wd != '0);
      wd_d[wr_ptr_q]    = push_wd;
      data_d[wr_ptr_q]  = push_wdata;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid_q  <= '0;
      wd_q     <= '0;
      data_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wd_q     <= wd_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = valid_q[rd_ptr_q];
  assign head_wd    = wd_q[rd_ptr_q];
  assign head_wdata = data_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates the register-file write port between MEM/WB and buffered divider results.
// Define WB_FIFO_BYPASS_EN to load a divider result straight into an idle port when the FIFO is empty.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          mem_wreg,
  input  logic [AW-1:0] mem_wd,
  input  logic [DW-1:0] mem_wdata,
  input  logic          div_valid,
  input  logic [AW-1:0] div_wd,
  input  logic [DW-1:0] div_wdata,
  output logic          div_ready,
  output logic          stallreq,
  output logic          wb_wreg,
  output logic [AW-1:0] wb_wd,
  output logic [DW-1:0] wb_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          head_valid;
  logic [AW-1:0] head_wd;
  logic [DW-1:0] head_wdata;
  logic [CW-1:0] count;
  logic          push, pop, kill_en;
  slot_e         slot;

  logic          wreg_q, wreg_d;
  logic [AW-1:0] wd_q, wd_d;
  logic [DW-1:0] wdata_q, wdata_d;

  always_comb begin
    div_ready = (count < CW'(DEPTH));
    stallreq  = div_valid & ~div_ready;
    if (stall[5] == STOP)
      slot = SLOT_HOLD;
    else if (stall[4] != STOP && mem_wreg == WRITE_ENABLE && mem_wd != '0)
      slot = SLOT_MEM;
    else if (count != '0)
      slot = SLOT_DRAIN;
    else
      slot = SLOT_IDLE;
`ifdef WB_FIFO_BYPASS_EN
    if (slot == SLOT_IDLE && div_valid && div_wd != '0)
      slot = SLOT_BYPASS;
`endif
    push    = div_valid & div_ready & (slot != SLOT_BYPASS);
    pop     = (slot == SLOT_DRAIN);
    kill_en = (slot == SLOT_MEM);
  end

  always_comb begin
    wreg_d  = 1'b0;
    wd_d    = '0;
    wdata_d = '0;
    case (slot)
      SLOT_HOLD: begin
        wreg_d  = wreg_q;
        wd_d    = wd_q;
        wdata_d = wdata_q;
      end
      SLOT_MEM: begin
        wreg_d  = 1'b1;
        wd_d    = mem_wd;
        wdata_d = mem_wdata;
      end
      // A killed or zero-destination head still burns the slot, writing nothing.
      SLOT_DRAIN: if (head_valid) begin
        wreg_d  = 1'b1;
        wd_d    = head_wd;
        wdata_d = head_wdata;
      end
      SLOT_BYPASS: begin
        wreg_d  = 1'b1;
        wd_d    = div_wd;
        wdata_d = div_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wreg_q  <= 1'b0;
      wd_q    <= '0;
      wdata_q <= '0;
    end else begin
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      wdata_q <= wdata_d;
    end
  end

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_wd    (div_wd),
    .push_wdata (div_wdata),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_wd    (mem_wd),
    .head_valid (head_valid),
    .head_wd    (head_wd),
    .head_wdata (head_wdata),
    .count      (count)
  );

  assign wb_wreg  = wreg_q;
  assign wb_wd    = wd_q;
  assign wb_wdata = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage: directed vectors queue expected writes, a monitor checks the port.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        mem_wreg, div_valid;
  logic [4:0]  mem_wd, div_wd;
  logic [31:0] mem_wdata, div_wdata;
  logic        div_ready, stallreq, wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;

  typedef struct packed { logic [4:0] wd; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic        hold_edge = 1'b0;
  logic        last_we = 1'b0;
  logic [4:0]  last_wd = '0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  wb_stage #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .div_valid(div_valid), .div_wd(div_wd), .div_wdata(div_wdata),
    .div_ready(div_ready), .stallreq(stallreq),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] wd, input logic [31:0] d);
    exp_q.push_back('{wd: wd, data: d});
  endtask

  task automatic mem(input logic en, input logic [4:0] wd, input logic [31:0] d);
    mem_wreg = en; mem_wd = wd; mem_wdata = d;
  endtask

  task automatic div(input logic en, input logic [4:0] wd, input logic [31:0] d);
    div_valid = en; div_wd = wd; div_wdata = d;
  endtask

  task automatic idle();
    mem(1'b0, 5'd0, 32'h0);
    div(1'b0, 5'd0, 32'h0);
    stall = 6'b0;
  endtask

  always @(posedge clk) hold_edge <= stall[5] & ~rst;

  // Monitor: a stalled WB must hold; otherwise every asserted write must match the queue head.
  always @(negedge clk) begin
    if (hold_edge) begin
      chk("hold_we", {31'b0, wb_wreg}, {31'b0, last_we});
      chk("hold_wd", {27'b0, wb_wd}, {27'b0, last_wd});
      chk("hold_data", wb_wdata, last_data);
    end else if (wb_wreg) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got wd=%0d data=%h, expected no write", wb_wd, wb_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_wd", {27'b0, wb_wd}, {27'b0, e.wd});
        chk("write_data", wb_wdata, e.data);
      end
    end
    last_we   = wb_wreg;
    last_wd   = wb_wd;
    last_data = wb_wdata;
  end

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    chk("rst_wreg", {31'b0, wb_wreg}, 32'd0);
    chk("rst_wd", {27'b0, wb_wd}, 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_ready", {31'b0, div_ready}, 32'd1);
    chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
    rst = 1'b0;
    step();

    // Pipeline pass-through
    mem(1'b1, 5'd5, 32'h1234); expect_wr(5'd5, 32'h1234); step();
    idle(); step();
    chk("idle_wreg", {31'b0, wb_wreg}, 32'd0);

    // Drain only into the first free slot
    mem(1'b1, 5'd1, 32'h1); div(1'b1, 5'd9, 32'hABCD); expect_wr(5'd1, 32'h1); step();
    div(1'b0, 5'd0, 32'h0);
    mem(1'b1, 5'd2, 32'h2); expect_wr(5'd2, 32'h2); step();
    mem(1'b1, 5'd3, 32'h3); expect_wr(5'd3, 32'h3); step();
    mem(1'b0, 5'd0, 32'h0); expect_wr(5'd9, 32'hABCD); step();
    idle(); step();

    // Full / backpressure
    mem(1'b1, 5'd4, 32'h4); div(1'b1, 5'd10, 32'hA0); #1;
    chk("ready_empty", {31'b0, div_ready}, 32'd1);
    expect_wr(5'd4, 32'h4); step();
    mem(1'b1, 5'd6, 32'h6); div(1'b1, 5'd11, 32'hB0); expect_wr(5'd6, 32'h6); step();
    mem(1'b1, 5'd8, 32'h8); div(1'b1, 5'd12, 32'hC0); #1;
    chk("full_ready", {31'b0, div_ready}, 32'd0);
    chk("full_stallreq", {31'b0, stallreq}, 32'd1);
    expect_wr(5'd8, 32'h8); step();
    mem(1'b0, 5'd0, 32'h0); #1;
    chk("full_ready2", {31'b0, div_ready}, 32'd0);
    chk("full_stallreq2", {31'b0, stallreq}, 32'd1);
    expect_wr(5'd10, 32'hA0); step();
    chk("after_drain_ready", {31'b0, div_ready}, 32'd1);
    chk("after_drain_stallreq", {31'b0, stallreq}, 32'd0);
    expect_wr(5'd11, 32'hB0); step();
    div(1'b0, 5'd0, 32'h0); expect_wr(5'd12, 32'hC0); step();
    idle(); step();

    // Kill: younger pipeline write to r7 cancels the buffered one
    mem(1'b1, 5'd1, 32'h11); div(1'b1, 5'd7, 32'hA); expect_wr(5'd1, 32'h11); step();
    div(1'b0, 5'd0, 32'h0);
    mem(1'b1, 5'd7, 32'hB); expect_wr(5'd7, 32'hB); step();
    mem(1'b0, 5'd0, 32'h0); step();
    chk("killed_slot_wreg", {31'b0, wb_wreg}, 32'd0);
    step();

    // Same-cycle push is not killed by the matching MEM write
    mem(1'b1, 5'd13, 32'hD1); div(1'b1, 5'd13, 32'hD2); expect_wr(5'd13, 32'hD1); step();
    idle(); expect_wr(5'd13, 32'hD2); step();
    step();

    // Zero-destination divider result handshakes but never writes
    mem(1'b1, 5'd1, 32'h1); div(1'b1, 5'd0, 32'hFF); #1;
    chk("wd0_ready", {31'b0, div_ready}, 32'd1);
    expect_wr(5'd1, 32'h1); step();
    idle(); step();
    chk("wd0_slot_wreg", {31'b0, wb_wreg}, 32'd0);
    step();

    // MEM stalled: bubble drains the queued entry
    mem(1'b1, 5'd2, 32'h22); div(1'b1, 5'd14, 32'hE0); expect_wr(5'd2, 32'h22); step();
    div(1'b0, 5'd0, 32'h0);
    stall = 6'b010000; mem(1'b1, 5'd3, 32'h33); expect_wr(5'd14, 32'hE0); step();
    idle(); step();

    // WB stalled: outputs hold, push still accepted
    mem(1'b1, 5'd15, 32'hF5); expect_wr(5'd15, 32'hF5); step();
    stall = 6'b110000; mem(1'b1, 5'd16, 32'h16); div(1'b1, 5'd17, 32'hF7); step();
    div(1'b0, 5'd0, 32'h0); step(); step();
    chk("stall_hold_wd", {27'b0, wb_wd}, 32'd15);
    stall = 6'b0; mem(1'b0, 5'd0, 32'h0); expect_wr(5'd17, 32'hF7); step();
    idle(); step();

    // Reset mid-operation discards a full FIFO
    mem(1'b1, 5'd1, 32'h1); div(1'b1, 5'd20, 32'hAA); expect_wr(5'd1, 32'h1); step();
    mem(1'b1, 5'd2, 32'h2); div(1'b1, 5'd21, 32'hBB); expect_wr(5'd2, 32'h2); step();
    idle(); rst = 1'b1; step();
    chk("mid_rst_wreg", {31'b0, wb_wreg}, 32'd0);
    chk("mid_rst_wd", {27'b0, wb_wd}, 32'd0);
    chk("mid_rst_wdata", wb_wdata, 32'd0);
    chk("mid_rst_ready", {31'b0, div_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wreg", {31'b0, wb_wreg}, 32'd0);
    end

    step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage. Owns the single register-file write port: drives its we/waddr/wdata.
- Merges two producers:
  - the in-order MEM/WB pipeline result;
  - late results from the multi-cycle divider, buffered in a small FIFO.
- Pipeline writes always win the port. Buffered divider results drain into free slots.
- Buffered entries that a younger pipeline write to the same register supersedes are cancelled.

Parameters:
- DEPTH, 2, divider-result FIFO depth (power of two, ≥2)
- AW, 5, register address width (`RegAddrBus)
- DW, 32, data width (`RegBus)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1)
- stall  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
- mem_wreg  in  1  MEM stage writes a register
- mem_wd  in  AW  MEM destination register
- mem_wdata  in  DW  MEM result
- div_valid  in  1  divider result available
- div_wd  in  AW  divider destination register
- div_wdata  in  DW  divider result
- div_ready  out  1  FIFO accepts a result this cycle
- stallreq  out  1  pipeline stall request
- wb_wreg  out  1  register-file write enable (registered)
- wb_wd  out  AW  register-file write address (registered)
- wb_wdata  out  DW  register-file write data (registered)

Behaviour:
- Reset (rst=1 at posedge): wb_wreg=0, wb_wd=0, wb_wdata=`ZeroWord; FIFO emptied, all entries invalid.
  - Combinational during and after reset: div_ready=1, stallreq=0.
  - Reset mid-operation discards buffered results. No write is issued for them.
- div_ready = (count < DEPTH).
- stallreq = div_valid & ~div_ready.
- Push: div_valid & div_ready at posedge. Entry {valid=1, wd, wdata} goes to the tail. Visible at head next cycle.
  - div_wd == 0: handshake completes, but the entry is stored invalid (never written).
- Slot selection each posedge, in priority order:
  1. stall[5]=1: outputs hold. No drain, no capture. Push is still allowed.
  2. stall[4]=0 and mem_wreg=1 and mem_wd≠0: outputs ← {1, mem_wd, mem_wdata}. No drain.
  3. Otherwise the slot is free. This covers stall[4]=1 (bubble), mem_wreg=0, and mem_wd=0.
     - FIFO non-empty: pop the head.
     - Head valid: outputs ← {1, head.wd, head.wdata}.
     - Head invalid: outputs ← {0, 0, 0}. The pop still consumes the cycle.
  4. FIFO empty and slot free: outputs ← {0, 0, `ZeroWord}.
- Kill (WAW ordering):
  - Trigger: case 2 captures mem_wd.
  - Effect: every FIFO entry resident at the start of the cycle with wd == mem_wd is marked invalid.
  - An entry pushed in the same cycle is not killed.
- Simultaneous push and pop: count is unchanged; pointers advance modulo DEPTH.
- Push is blocked when full, even if a pop occurs that cycle.
- Latency:
  - MEM → port: 1 cycle.
  - Divider → port: ≥2 cycles (push edge, then drain edge).

Optional Feature:
- Macro: WB_FIFO_BYPASS_EN.
- Defined: when the FIFO is empty, the slot is free (cases 3/4), and div_valid=1 with div_wd≠0:
  - the result loads directly into the outputs at that edge (1-cycle latency);
  - no push occurs;
  - div_ready remains 1.
- Undefined: all divider results pass through the FIFO (≥2-cycle latency).

Decomposition:
- Shared defines (defines.v): `RstEnable, `WriteEnable, `ZeroWord, `RegAddrBus, `RegBus, `NOPRegAddr, `Stop.
- Sub-module wb_fifo:
  - synchronous FIFO, DEPTH entries of {valid, wd, wdata};
  - ports: push, pop, kill_en, kill_wd, head, count.
- wb_stage holds the arbitration and output register.

Test Plan:
- Reset mid-operation:
  - Stimulus: FIFO holding 2 valid entries; rst=1 for one cycle.
  - Response: wb_wreg=0, wb_wd=0, wb_wdata=0, div_ready=1; no later write of those entries.
- Pipeline pass-through:
  - Stimulus: mem_wreg=1, mem_wd=5, mem_wdata=32'h1234, stall=0.
  - Response: next cycle wb_wreg=1, wb_wd=5, wb_wdata=32'h1234.
- Drain into a free slot:
  - Stimulus: div result (wd=9, 32'hABCD) pushed while MEM writes for 3 cycles, then mem_wreg=0.
  - Response: result appears only in the first free cycle: wb_wd=9, wb_wdata=32'hABCD.
- Full / backpressure:
  - Stimulus: 2 pushes while MEM is busy; third div_valid.
  - Response: div_ready=0, stallreq=1 until a drain; third result is accepted after that drain.
- Kill:
  - Stimulus: FIFO holds {wd=7, 32'hA}; MEM writes wd=7, 32'hB.
  - Response: port shows 32'hB; 32'hA is never written; the following free slot shows wb_wreg=0.
- Stall interaction:
  - stall=6'b010000 with one entry queued: the entry drains into the bubble.
  - stall=6'b110000: outputs hold their previous values for the whole stall.
